// File: rtl/line_point_gen.sv
// Streams (x, y) points along y = a + b*x with one add per point and y saturated to the screen.
// Optional LINE_POINT_GEN_CLIP_EN: out-of-range points are skipped instead of being presented saturated.
module line_point_gen #(
  parameter int unsigned X_START   = 0,
  parameter int unsigned X_END     = 1023,
  parameter int unsigned X_STEP    = 1,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned FRAC_BITS = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic signed [17:0] a_in,
  input  logic signed [24:0] b_in,
  input  logic               valid_in,
  input  logic               ready_in,
  output logic [10:0]        x_out,
  output logic [9:0]         y_out,
  output logic               point_valid_out,
  output logic               oob_out,
  output logic               busy_out,
  output logic               done_out
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  localparam logic signed [37:0] XS    = 38'(X_START);
  localparam logic signed [37:0] XSTEP = 38'(X_STEP);
  localparam logic signed [37:0] RND   = 38'(1) << (FRAC_BITS - 1);
  localparam logic signed [37:0] YMAX  = 38'(V_ACTIVE - 1);

  state_t             state_q, state_d;
  logic signed [17:0] a_q, a_d;
  logic signed [24:0] b_q, b_d;
  logic signed [37:0] acc_q, acc_d;
  logic signed [37:0] bstep_q, bstep_d;
  logic [10:0]        x_q, x_d;

  logic signed [37:0] a_ext, b_ext, y_full;
  logic               in_range, last_pt, adv;

  always_comb begin
    a_ext    = {{20{a_q[17]}}, a_q};
    b_ext    = {{13{b_q[24]}}, b_q};
    // Adding half an LSB before the arithmetic shift rounds half toward +inf.
    y_full   = (acc_q + RND) >>> FRAC_BITS;
    in_range = !y_full[37] && (y_full <= YMAX);
    last_pt  = (32'(x_q) + X_STEP) > X_END;
  end

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    acc_d           = acc_q;
    bstep_d         = bstep_q;
    x_d             = x_q;
    adv             = 1'b0;
    point_valid_out = 1'b0;
    oob_out         = 1'b0;
    x_out           = '0;
    y_out           = '0;
    busy_out        = (state_q != IDLE);
    done_out        = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d   = (a_ext <<< FRAC_BITS) + b_ext * XS;
        bstep_d = b_ext * XSTEP;
        x_d     = 11'(X_START);
        state_d = EMIT;
      end
      EMIT: begin
        x_out = x_q;
        y_out = y_full[37] ? '0 : (in_range ? y_full[9:0] : 10'(V_ACTIVE - 1));
`ifdef LINE_POINT_GEN_CLIP_EN
        // Hidden points advance without waiting for the consumer.
        point_valid_out = in_range;
        adv             = !in_range || ready_in;
`else
        point_valid_out = 1'b1;
        oob_out         = !in_range;
        adv             = ready_in;
`endif
        if (adv) begin
          if (last_pt) begin
            state_d = DONE;
          end else begin
            acc_d = acc_q + bstep_q;
            x_d   = x_q + 11'(X_STEP);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      bstep_q <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      bstep_q <= bstep_d;
      x_q     <= x_d;
    end
  end

endmodule

// File: tb/tb_line_point_gen.sv
// Bench for line_point_gen: table vectors, cycle-exact sequences and random lines vs an arithmetic model.
module tb_line_point_gen;
  localparam int F   = 6;
  localparam int V   = 768;
  localparam int XS0 = 0, XE0 = 3,  ST0 = 1;
  localparam int XS1 = 5, XE1 = 19, ST1 = 4;

  logic               clk = 1'b0;
  logic               rst, valid, ready;
  logic signed [17:0] a;
  logic signed [24:0] b;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic        pv0, pv1, oob0, oob1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  line_point_gen #(.X_START(XS0), .X_END(XE0), .X_STEP(ST0), .V_ACTIVE(V), .FRAC_BITS(F)) dut0 (
    .clk_in(clk), .rst_in(rst), .a_in(a), .b_in(b), .valid_in(valid), .ready_in(ready),
    .x_out(x0), .y_out(y0), .point_valid_out(pv0), .oob_out(oob0), .busy_out(busy0), .done_out(done0));

  line_point_gen #(.X_START(XS1), .X_END(XE1), .X_STEP(ST1), .V_ACTIVE(V), .FRAC_BITS(F)) dut1 (
    .clk_in(clk), .rst_in(rst), .a_in(a), .b_in(b), .valid_in(valid), .ready_in(ready),
    .x_out(x1), .y_out(y1), .point_valid_out(pv1), .oob_out(oob1), .busy_out(busy1), .done_out(done1));

  typedef struct { int x; int y; bit oob; } pt_t;
  typedef struct { longint a; longint b; int y[4]; bit oob[4]; } vec_t;

  int   vectors = 0, miscompares = 0;
  pt_t  got0[$], got1[$], exp0[$], exp1[$];
  int   done_cnt0, done_cnt1;
  vec_t tbl[9];

  task automatic check(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // y = a + b*x/2^F rounded half up, clamped to the screen.
  function automatic pt_t ref_pt(input int x, input longint av, input longint bv);
    pt_t    p;
    longint n, yf;
    n  = av * (64'sd1 << F) + bv * x + (64'sd1 << (F - 1));
    yf = n / (64'sd1 << F);
    if (n < 0 && (n % (64'sd1 << F)) != 0) yf--;
    p.x = x;
    if (yf < 0)          begin p.y = 0;     p.oob = 1'b1; end
    else if (yf > V - 1) begin p.y = V - 1; p.oob = 1'b1; end
    else                 begin p.y = int'(yf); p.oob = 1'b0; end
    return p;
  endfunction

  function automatic bit shown(input pt_t p);
`ifdef LINE_POINT_GEN_CLIP_EN
    return !p.oob;
`else
    return 1'b1;
`endif
  endfunction

  task automatic build_exp(input longint av, input longint bv);
    pt_t p;
    exp0.delete();
    exp1.delete();
    for (int x = XS0; x <= XE0; x += ST0) begin
      p = ref_pt(x, av, bv);
      if (shown(p)) exp0.push_back(p);
    end
    for (int x = XS1; x <= XE1; x += ST1) begin
      p = ref_pt(x, av, bv);
      if (shown(p)) exp1.push_back(p);
    end
  endtask

  task automatic cmp_pts(input string tag, input pt_t g[$], input pt_t e[$]);
    check($sformatf("%s_count", tag), g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++) begin
      check($sformatf("%s_x[%0d]", tag, i), g[i].x, e[i].x);
      check($sformatf("%s_y[%0d]", tag, i), g[i].y, e[i].y);
      check($sformatf("%s_oob[%0d]", tag, i), g[i].oob, e[i].oob);
    end
  endtask

  task automatic pulse(input longint av, input longint bv);
    @(negedge clk);
    a     = 18'(av);
    b     = 25'(bv);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Collects accepted points from both DUTs; a second valid_in can be injected mid-line.
  task automatic run_line(input longint av, input longint bv, input bit rnd_ready, input int inject_at);
    got0.delete();
    got1.delete();
    done_cnt0 = 0;
    done_cnt1 = 0;
    build_exp(av, bv);
    pulse(av, bv);
    for (int c = 0; c < 300 && !(done_cnt0 > 0 && done_cnt1 > 0); c++) begin
      @(negedge clk);
      ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      valid = (c == inject_at);
      if (c == inject_at) a = '0;
      if (pv0 && ready) got0.push_back('{int'(x0), int'(y0), oob0});
      if (pv1 && ready) got1.push_back('{int'(x1), int'(y1), oob1});
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
    end
    valid = 1'b0;
    ready = 1'b1;
    check("done0_once", done_cnt0, 1);
    check("done1_once", done_cnt1, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pv0"}, pv0, 0);     check({tag, "_pv1"}, pv1, 0);
    check({tag, "_x0"}, x0, 0);       check({tag, "_y0"}, y0, 0);
    check({tag, "_oob0"}, oob0, 0);   check({tag, "_busy0"}, busy0, 0);
    check({tag, "_done0"}, done0, 0); check({tag, "_busy1"}, busy1, 0);
    check({tag, "_done1"}, done1, 0); check({tag, "_x1"}, x1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pt_t ql[$];
    int  bp_x[8]    = '{0, 1, 1, 1, 1, 2, 3, 0};
    bit  bp_pv[8]   = '{1, 1, 1, 1, 1, 1, 1, 0};
    bit  bp_done[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    tbl[0] = '{100, 64,  '{100, 101, 102, 103}, '{0, 0, 0, 0}};
    tbl[1] = '{10,  -32, '{10, 10, 9, 9},       '{0, 0, 0, 0}};
    tbl[2] = '{-5,  0,   '{0, 0, 0, 0},         '{1, 1, 1, 1}};
    tbl[3] = '{760, 640, '{760, 767, 767, 767}, '{0, 1, 1, 1}};
    tbl[4] = '{0,   96,  '{0, 2, 3, 5},         '{0, 0, 0, 0}};
    tbl[5] = '{767, 0,   '{767, 767, 767, 767}, '{0, 0, 0, 0}};
    tbl[6] = '{768, 0,   '{767, 767, 767, 767}, '{1, 1, 1, 1}};
    tbl[7] = '{0,   -32, '{0, 0, 0, 0},         '{0, 0, 1, 1}};
    tbl[8] = '{0,   32,  '{0, 1, 1, 2},         '{0, 0, 0, 0}};

    rst = 1'b1; valid = 1'b0; ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst   = 1'b0;
    ready = 1'b1;

    // Cycle-exact latency, throughput, done and busy timing.
    pulse(100, 64);
    check("lat_T1_pv", pv0, 0);
    check("lat_T1_busy", busy0, 1);
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("lat_T%0d_pv", k), pv0, (k <= 5));
      check($sformatf("lat_T%0d_done", k), done0, (k == 6));
      check($sformatf("lat_T%0d_busy", k), busy0, (k <= 6));
      if (k <= 5) begin
        check($sformatf("lat_T%0d_x", k), x0, k - 2);
        check($sformatf("lat_T%0d_y", k), y0, 98 + k);
      end
    end
    repeat (12) @(negedge clk);

    // Backpressure: ready low for three cycles while (1,101) is presented.
    pulse(100, 64);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      ready = !(k >= 3 && k <= 5);
      check($sformatf("bp_T%0d_pv", k), pv0, bp_pv[k-2]);
      check($sformatf("bp_T%0d_done", k), done0, bp_done[k-2]);
      if (bp_pv[k-2]) begin
        check($sformatf("bp_T%0d_x", k), x0, bp_x[k-2]);
        check($sformatf("bp_T%0d_y", k), y0, 100 + bp_x[k-2]);
      end
    end
    ready = 1'b1;
    repeat (12) @(negedge clk);

    // Table vectors: dut0 against hand-derived values, dut1 against the model.
    for (int t = 0; t < 9; t++) begin
      run_line(tbl[t].a, tbl[t].b, 1'b0, -1);
      ql.delete();
      for (int i = 0; i < 4; i++) begin
        pt_t p;
        p = '{i, tbl[t].y[i], tbl[t].oob[i]};
        if (shown(p)) ql.push_back(p);
      end
      cmp_pts($sformatf("tbl%0d_d0", t), got0, ql);
      cmp_pts($sformatf("tbl%0d_d1", t), got1, exp1);
    end

    // valid_in during EMIT must be ignored.
    run_line(760, 640, 1'b0, 1);
    cmp_pts("inj_d0", got0, exp0);
    cmp_pts("inj_d1", got1, exp1);
    repeat (4) @(negedge clk);
    check("inj_busy0", busy0, 0);

    // Reset while the second point is presented: line discarded, no done.
    pulse(300, 64);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_x", x0, 1);
    check("rst_mid_pv", pv0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rst_nodone0_%0d", k), done0, 0);
      check($sformatf("rst_nodone1_%0d", k), done1, 0);
    end
    run_line(50, -64, 1'b0, -1);
    cmp_pts("restart_d0", got0, exp0);
    cmp_pts("restart_d1", got1, exp1);

    // Random lines with random backpressure.
    for (int r = 0; r < 30; r++) begin
      longint ra, rb;
      ra = longint'($urandom_range(0, 2600)) - 800;
      rb = longint'($urandom_range(0, 4000)) - 2000;
      run_line(ra, rb, 1'b1, -1);
      cmp_pts($sformatf("rnd%0d_d0", r), got0, exp0);
      cmp_pts($sformatf("rnd%0d_d1", r), got1, exp1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
